m_adder_comparator_counter: RTL and testbench

M_ADDER_COMPARATOR_COUNTER -- requirements
Module: m_adder_comparator_counter

---
 rtl/m_adder_comparator_counter.sv | 68 ++++++
 tb/tb_m_adder_comparator_counter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/m_adder_comparator_counter.sv
// Combinational adder and unsigned magnitude comparator sharing a block with an
// up/down load/clear counter; only the counter is clocked or reset.
module m_adder_comparator_counter #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] add_a,
  input  logic [WIDTH-1:0] add_b,
  input  logic             add_cin,
  output logic [WIDTH-1:0] add_sum,
  output logic             add_cout,
  input  logic [WIDTH-1:0] cmp_a,
  input  logic [WIDTH-1:0] cmp_b,
  output logic             cmp_lt,
  output logic             cmp_eq,
  output logic             cmp_gt,
  input  logic [WIDTH-1:0] cnt_d,
  input  logic             cnt_clr,
  input  logic             cnt_load,
  input  logic             cnt_up,
  input  logic             cnt_en,
  output logic [WIDTH-1:0] cnt_q
);

  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // One extra bit so the carry-out falls out of the addition itself.
  always_comb begin
    add_full = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
  end

  assign add_sum  = add_full[WIDTH-1:0];
  assign add_cout = add_full[WIDTH];

  assign cmp_lt = (cmp_a <  cmp_b);
  assign cmp_eq = (cmp_a == cmp_b);
  assign cmp_gt = (cmp_a >  cmp_b);

  // Clear beats load beats count; increment/decrement wrap naturally at WIDTH bits.
  always_comb begin
    count_d = count_q;
    if (cnt_clr) begin
      count_d = '0;
    end else if (cnt_load) begin
      count_d = cnt_d;
    end else if (cnt_en) begin
      if (cnt_up) begin
        count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
        count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign cnt_q = count_q;

endmodule

// File: tb/tb_m_adder_comparator_counter.sv
// Scoreboard bench: the driver pushes expectations from an arithmetic model,
// a monitor pops and compares one record after each rising edge.
module tb_m_adder_comparator_counter;
  localparam int W = 14;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] add_a = '0, add_b = '0, cmp_a = '0, cmp_b = '0, cnt_d = '0;
  logic         add_cin = 1'b0, cnt_clr = 1'b0, cnt_load = 1'b0, cnt_up = 1'b0, cnt_en = 1'b0;
  logic [W-1:0] add_sum, cnt_q;
  logic         add_cout, cmp_lt, cmp_eq, cmp_gt;

  typedef struct {
    int sum;
    int cout;
    int lt;
    int eq;
    int gt;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;

  always #5 clk = ~clk;

  m_adder_comparator_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt),
    .cnt_d(cnt_d), .cnt_clr(cnt_clr), .cnt_load(cnt_load), .cnt_up(cnt_up), .cnt_en(cnt_en),
    .cnt_q(cnt_q)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a falling edge with the inputs for the coming rising edge.
  task automatic step();
    exp_t e;
    int   s;
    s      = int'(add_a) + int'(add_b) + int'(add_cin);
    e.sum  = s % M;
    e.cout = (s >= M) ? 1 : 0;
    e.lt   = (int'(cmp_a) <  int'(cmp_b)) ? 1 : 0;
    e.eq   = (int'(cmp_a) == int'(cmp_b)) ? 1 : 0;
    e.gt   = (int'(cmp_a) >  int'(cmp_b)) ? 1 : 0;
    if (!rst)          model_cnt = 0;
    else if (cnt_clr)  model_cnt = 0;
    else if (cnt_load) model_cnt = int'(cnt_d);
    else if (cnt_en)   model_cnt = cnt_up ? (model_cnt + 1) % M : (model_cnt + M - 1) % M;
    e.cnt = model_cnt;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("add_sum",  int'(add_sum),  e.sum);
        chk("add_cout", int'(add_cout), e.cout);
        chk("cmp_lt",   int'(cmp_lt),   e.lt);
        chk("cmp_eq",   int'(cmp_eq),   e.eq);
        chk("cmp_gt",   int'(cmp_gt),   e.gt);
        chk("cnt_q",    int'(cnt_q),    e.cnt);
      end
    end
  end

  initial begin : driver
    #1;
    chk("reset_cnt", int'(cnt_q), 0);
    @(negedge clk);
    cnt_en = 1'b1; cnt_up = 1'b1;
    step(); step();
    chk("held_in_reset", int'(cnt_q), 0);
    rst = 1'b1;

    // Subtraction via two's complement, and counter load of 0
    add_a = 14'd100; add_b = ~14'd25; add_cin = 1'b1;
    cmp_a = 14'd5; cmp_b = 14'd9;
    cnt_load = 1'b1; cnt_d = '0; cnt_en = 1'b0;
    #1;
    chk("sub_sum", int'(add_sum), 75);
    chk("sub_cout", int'(add_cout), 1);
    chk("lt_5_9", int'({cmp_lt, cmp_eq, cmp_gt}), 4);
    step();

    add_a = 14'h3FFF; add_b = 14'd1; add_cin = 1'b0;
    cmp_a = 14'd9; cmp_b = 14'd9;
    #1;
    chk("ovf_sum", int'(add_sum), 0);
    chk("ovf_cout", int'(add_cout), 1);
    chk("eq_9_9", int'({cmp_lt, cmp_eq, cmp_gt}), 2);
    step();

    cmp_a = 14'h3FFF; cmp_b = '0;
    #1;
    chk("gt_max_0", int'({cmp_lt, cmp_eq, cmp_gt}), 1);

    cnt_load = 1'b0; cnt_en = 1'b1; cnt_up = 1'b1;
    repeat (200) step();
    chk("up_200", int'(cnt_q), 200);
    cnt_en = 1'b0;
    repeat (3) step();
    chk("hold_200", int'(cnt_q), 200);

    cnt_load = 1'b1; cnt_d = '0; step();
    cnt_load = 1'b0; cnt_en = 1'b1; cnt_up = 1'b0; step();
    chk("down_wrap", int'(cnt_q), 16'h3FFF);
    cnt_load = 1'b1; cnt_d = 14'h3FFF; cnt_en = 1'b0; step();
    cnt_load = 1'b0; cnt_en = 1'b1; cnt_up = 1'b1; step();
    chk("up_wrap", int'(cnt_q), 0);

    cnt_clr = 1'b1; cnt_load = 1'b1; cnt_en = 1'b1; cnt_d = 14'd7; step();
    chk("clr_wins", int'(cnt_q), 0);
    cnt_clr = 1'b0; step();
    chk("load_wins", int'(cnt_q), 7);

    cnt_d = 14'd42; step();
    cnt_load = 1'b0; cnt_en = 1'b0;
    chk("pre_async", int'(cnt_q), 42);
    #2 rst = 1'b0;
    #1 chk("async_clear", int'(cnt_q), 0);
    model_cnt = 0;
    cnt_en = 1'b1; cnt_up = 1'b1;
    @(negedge clk);
    repeat (3) step();
    chk("reset_held_en", int'(cnt_q), 0);
    rst = 1'b1; cnt_en = 1'b0;

    repeat (400) begin
      add_a    = W'($urandom);
      add_b    = W'($urandom);
      add_cin  = 1'($urandom);
      cmp_a    = W'($urandom);
      cmp_b    = ($urandom_range(0, 3) == 0) ? cmp_a : W'($urandom);
      cnt_d    = ($urandom_range(0, 1) == 0) ? W'($urandom) : W'($urandom_range(M - 3, M - 1));
      cnt_clr  = ($urandom_range(0, 15) == 0);
      cnt_load = ($urandom_range(0, 7) == 0);
      cnt_en   = ($urandom_range(0, 3) != 0);
      cnt_up   = 1'($urandom);
      rst      = ($urandom_range(0, 63) != 0);
      step();
    end
    rst = 1'b1; cnt_clr = 1'b0; cnt_load = 1'b0; cnt_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
